// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, exponent constants and converter state encoding.
package fp32_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int INT_W    = 32;

   // Exponent of an operand whose leading one already sits at bit 31.
   localparam logic [EXP_W-1:0] EXP_INIT = 8'd158;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Rounds a left-normalized 32-bit magnitude to a packed FP32 value,
// using round-to-nearest-even.
module fp32_round_rne
   import fp32_pkg::*;
(
   input  logic             sign,
   input  logic [EXP_W-1:0] exp_in,
   input  logic [INT_W-1:0] mag,
   output logic [INT_W-1:0] fp_out
);

   logic [MANT_W:0]  mant_sum;
   logic [EXP_W-1:0] exp_adj;

   function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
      return guard & (sticky | lsb);
   endfunction

   // Bit 31 is the hidden one; a carry out of the mantissa lands on 1.0 * 2^(e+1).
   always_comb begin
      mant_sum = {1'b0, mag[INT_W-2 -: MANT_W]}
               + {{MANT_W{1'b0}}, rne_up(mag[8], mag[7], |mag[6:0])};
      exp_adj  = exp_in + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]};
      fp_out   = {sign, exp_adj, mant_sum[MANT_W-1:0]};
   end

endmodule

// File: rtl/int2fp_serial.sv
// Serial signed int32 -> FP32 converter: one normalization shift per cycle,
// then a single rounding cycle, with valid/ready handshakes on both sides.
module int2fp_serial
   import fp32_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [INT_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic        [INT_W-1:0] out_data
);

   state_t           state;
   state_t           state_nx;
   logic             sign_r;
   logic [INT_W-1:0] mag_r;
   logic [EXP_W-1:0] exp_r;
   logic [INT_W-1:0] abs_in;
   logic [INT_W-1:0] rnd_data;

   // Negating -2^31 wraps back to 0x80000000, which is the wanted magnitude.
   function automatic logic [INT_W-1:0] magnitude(input logic signed [INT_W-1:0] v);
      logic [INT_W-1:0] neg;
      neg = $unsigned(-v);
      return v[INT_W-1] ? neg : $unsigned(v);
   endfunction

   assign abs_in    = magnitude(in_data);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   fp32_round_rne u_round (
      .sign   (sign_r),
      .exp_in (exp_r),
      .mag    (mag_r),
      .fp_out (rnd_data)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = (abs_in == '0) ? DONE : NORM;
         NORM:    if (mag_r[INT_W-1]) state_nx = ROUND;
         ROUND:   state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         sign_r   <= 1'b0;
         mag_r    <= '0;
         exp_r    <= '0;
         out_data <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_r <= in_data[INT_W-1];
                  mag_r  <= abs_in;
                  exp_r  <= EXP_INIT;
                  if (abs_in == '0) out_data <= '0;
               end
            end
            NORM: begin
               if (!mag_r[INT_W-1]) begin
                  mag_r <= mag_r << 1;
                  exp_r <= exp_r - 1'b1;
               end
            end
            ROUND:   out_data <= rnd_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_int2fp_serial.sv
// Randomized self-checking bench for int2fp_serial against an arithmetic FP32 model.
module tb_int2fp_serial;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic        [31:0] out_data;

   int n_checks = 0;
   int n_errors = 0;

   int2fp_serial dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint ref_mag(input logic [31:0] d);
      longint m;
      m = longint'({32'd0, d});
      if (d[31]) m = 64'd4294967296 - m;
      return m;
   endfunction

   function automatic int ref_msb(input longint m);
      int k;
      k = 0;
      for (int i = 0; i < 32; i++)
         if (m >= (64'd1 << i)) k = i;
      return k;
   endfunction

   // Value = m * 2^0; keep 24 significant bits, round the dropped remainder to nearest-even.
   function automatic logic [31:0] ref_fp(input logic [31:0] d);
      longint m, q, r, half;
      int     k, e, sh;
      logic [63:0] qb;
      logic [31:0] eb;
      m = ref_mag(d);
      if (m == 0) return 32'h0;
      k = ref_msb(m);
      e = 127 + k;
      if (k <= 23) begin
         q = m << (23 - k);
      end else begin
         sh   = k - 23;
         q    = m >> sh;
         r    = m - (q << sh);
         half = 64'd1 << (sh - 1);
         if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      qb = q;
      eb = e;
      return {d[31], eb[7:0], qb[22:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] d);
      longint m;
      m = ref_mag(d);
      if (m == 0) return 1;
      return 3 + (31 - ref_msb(m));
   endfunction

   task automatic convert(input logic [31:0] d, input logic [31:0] exp_d, input int exp_l,
                          input int hold);
      int          cyc;
      logic [31:0] held;
      @(negedge clk);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 60);
      check("latency", 32'(cyc), 32'(exp_l));
      if (!out_valid) return;
      check("out_data", out_data, exp_d);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         in_data  = $urandom;
         @(negedge clk);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_out_data", out_data, held);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_out_data", out_data, held);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      convert(32'h0000_0001, 32'h3F80_0000, 34, 0);
      convert(32'hFFFF_FFFF, 32'hBF80_0000, 34, 1);
      convert(32'h8000_0000, 32'hCF00_0000, 3, 0);
      convert(32'h7FFF_FFFF, 32'h4F00_0000, 4, 2);
      convert(32'd16777217, 32'h4B80_0000, 10, 0);
      convert(32'd16777219, 32'h4B80_0002, 10, 0);
      convert(32'h0000_0000, 32'h0000_0000, 1, 0);
      convert(32'h0000_0064, 32'h42C8_0000, 28, 10);

      // Reset during normalization of 1: nothing may come out.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0000_0001;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_data", out_data, 32'h0);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) check("midrst_no_output", {31'd0, out_valid}, 32'd0);
      end
      check("midrst_idle_after", {31'd0, in_ready}, 32'd1);
      convert(32'd5, 32'h40A0_0000, 32, 0);

      for (int n = 0; n < 60; n++) begin
         d = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) d = -d;
         convert(d, ref_fp(d), ref_lat(d), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
